// File: rtl/exec_unit_pkg.sv
// Shared widths, op encoding and FSM state encoding for the execution unit.
package exec_unit_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int ID_W_DEF    = 4;
    localparam int MUL_LAT_DEF = 3;
    localparam int OP_W        = 5;
    localparam int PC_INC      = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_BEQ    = 5'd10,
        OP_BNE    = 5'd11,
        OP_BLT    = 5'd12,
        OP_BGE    = 5'd13,
        OP_BLTU   = 5'd14,
        OP_BGEU   = 5'd15,
        OP_JALR   = 5'd16,
        OP_MUL    = 5'd17,
        OP_MULH   = 5'd18,
        OP_MULHSU = 5'd19,
        OP_MULHU  = 5'd20,
        OP_DIV    = 5'd21,
        OP_DIVU   = 5'd22,
        OP_REM    = 5'd23,
        OP_REMU   = 5'd24
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    function automatic logic is_mul(op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/exec_div.sv
// Restoring radix-2 divider: one quotient bit per enabled cycle, XLEN iterations.
module exec_div
    import exec_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            i_en,
    input  logic            i_kill,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_quot,
    output logic [XLEN-1:0] o_rem
);

    localparam int CW = $clog2(XLEN);

    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_d;
    logic [XLEN-1:0] r_a;
    logic [XLEN:0]   r_r;
    logic            r_negq;
    logic            r_negr;
    logic            r_dz;

    logic            w_sa;
    logic            w_sb;
    logic [XLEN+1:0] w_sh;
    logic [XLEN+1:0] w_diff;
    logic            w_ge;
    logic [XLEN:0]   w_nr;
    logic [XLEN-1:0] w_nq;

    assign w_sa   = i_signed & i_a[XLEN-1];
    assign w_sb   = i_signed & i_b[XLEN-1];
    assign w_sh   = {r_r, r_q[XLEN-1]};
    assign w_diff = w_sh - {2'b00, r_d};
    assign w_ge   = !w_diff[XLEN+1];
    assign w_nr   = w_ge ? w_diff[XLEN:0] : w_sh[XLEN:0];
    assign w_nq   = {r_q[XLEN-2:0], w_ge};

    // Done is raised during the last iteration so the caller can register
    // the final (post-iteration) result on the same edge.
    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CW'(XLEN - 1));
    // Overflow (most-negative / -1) falls out naturally: |a| = 2^(XLEN-1), negated back.
    assign o_quot = r_dz ? '1  : (r_negq ? -w_nq : w_nq);
    assign o_rem  = r_dz ? r_a : (r_negr ? -w_nr[XLEN-1:0] : w_nr[XLEN-1:0]);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_a    <= '0;
            r_r    <= '0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
            r_dz   <= 1'b0;
        end else if (i_en) begin
            if (i_kill) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_q    <= w_sa ? -i_a : i_a;
                r_d    <= w_sb ? -i_b : i_b;
                r_a    <= i_a;
                r_r    <= '0;
                r_negq <= w_sa ^ w_sb;
                r_negr <= w_sa;
                r_dz   <= (i_b == '0);
            end else if (r_busy) begin
                r_q <= w_nq;
                r_r <= w_nr;
                if (o_done) begin
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Integer execution unit: single-cycle ALU/branch/JALR, pipelined multiply,
// iterative divide, one result register on the CDB handshake.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ID_W    = ID_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ID_W-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_tag,
    output logic [XLEN-1:0] out_val,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target
);

    localparam int SHW = $clog2(XLEN);
    localparam int MP  = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic [ID_W-1:0] r_tag;
    logic            r_is_rem;
    logic [XLEN-1:0] r_mul_pipe [MP];
    logic            r_out_valid;
    logic [ID_W-1:0] r_out_tag;
    logic [XLEN-1:0] r_out_val;
    logic            r_out_taken;
    logic [XLEN-1:0] r_out_target;

    op_t               w_op;
    logic              w_accept;
    logic [XLEN-1:0]   w_sum;
    logic              w_lt;
    logic              w_ltu;
    logic              w_eq;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_alu_res;
    logic              w_alu_tk;
    logic [XLEN-1:0]   w_alu_tgt;
    logic              w_ma_sgn;
    logic              w_mb_sgn;
    logic [2*XLEN-1:0] w_ma;
    logic [2*XLEN-1:0] w_mb;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic              w_div_busy;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_quot;
    logic [XLEN-1:0]   w_div_rem;

    assign w_op     = op_t'(in_op);
    assign in_ready = rdy_in && (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready && !flush;

    assign w_sum   = in_a + in_b;
    assign w_lt    = $signed(in_a) < $signed(in_b);
    assign w_ltu   = in_a < in_b;
    assign w_eq    = in_a == in_b;
    assign w_shamt = in_b[SHW-1:0];

    always_comb begin
        w_alu_res = w_sum;
        w_alu_tk  = 1'b0;
        w_alu_tgt = '0;
        case (w_op)
            OP_SUB:  w_alu_res = in_a - in_b;
            OP_SLL:  w_alu_res = in_a << w_shamt;
            OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt};
            OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_ltu};
            OP_XOR:  w_alu_res = in_a ^ in_b;
            OP_SRL:  w_alu_res = in_a >> w_shamt;
            OP_SRA:  w_alu_res = $signed(in_a) >>> w_shamt;
            OP_OR:   w_alu_res = in_a | in_b;
            OP_AND:  w_alu_res = in_a & in_b;
            OP_BEQ:  begin w_alu_res = '0; w_alu_tk = w_eq;  end
            OP_BNE:  begin w_alu_res = '0; w_alu_tk = !w_eq; end
            OP_BLT:  begin w_alu_res = '0; w_alu_tk = w_lt;  end
            OP_BGE:  begin w_alu_res = '0; w_alu_tk = !w_lt; end
            OP_BLTU: begin w_alu_res = '0; w_alu_tk = w_ltu; end
            OP_BGEU: begin w_alu_res = '0; w_alu_tk = !w_ltu; end
            OP_JALR: begin
                w_alu_res = in_pc + XLEN'(PC_INC);
                w_alu_tgt = w_sum & ~XLEN'(1);
                w_alu_tk  = 1'b1;
            end
            default: w_alu_res = w_sum;
        endcase
    end

    // Sign-extend both operands to 2*XLEN so one unsigned multiply covers every signedness mix.
    assign w_ma_sgn  = (w_op == OP_MULH || w_op == OP_MULHSU) && in_a[XLEN-1];
    assign w_mb_sgn  = (w_op == OP_MULH) && in_b[XLEN-1];
    assign w_ma      = {{XLEN{w_ma_sgn}}, in_a};
    assign w_mb      = {{XLEN{w_mb_sgn}}, in_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (w_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    exec_div #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst_in   (rst_in),
        .i_en     (rdy_in),
        .i_kill   (flush),
        .i_start  (w_accept && is_div(w_op)),
        .i_signed (w_op == OP_DIV || w_op == OP_REM),
        .i_a      (in_a),
        .i_b      (in_b),
        .o_busy   (w_div_busy),
        .o_done   (w_div_done),
        .o_quot   (w_div_quot),
        .o_rem    (w_div_rem)
    );

    // Free-running delay line; the product issued on cycle 0 sits in stage k after k enabled cycles.
    always_ff @(posedge clk) begin
        if (rdy_in) begin
            r_mul_pipe[0] <= w_mul_res;
            for (int i = 1; i < MP; i++) r_mul_pipe[i] <= r_mul_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_tag        <= '0;
            r_is_rem     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_tag    <= '0;
            r_out_val    <= '0;
            r_out_taken  <= 1'b0;
            r_out_target <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_out_valid <= 1'b0;
                r_state     <= IDLE;
                r_cnt       <= '0;
            end else begin
                if (r_out_valid && out_ready) r_out_valid <= 1'b0;
                case (r_state)
                    IDLE: if (w_accept) begin
                        r_tag    <= in_tag;
                        r_is_rem <= is_rem(w_op);
                        r_cnt    <= '0;
                        if (is_div(w_op)) begin
                            r_state <= DIV;
                        end else if (is_mul(w_op) && MUL_LAT > 1) begin
                            r_state <= MUL;
                        end else begin
                            r_out_valid  <= 1'b1;
                            r_out_tag    <= in_tag;
                            r_out_val    <= is_mul(w_op) ? w_mul_res : w_alu_res;
                            r_out_taken  <= is_mul(w_op) ? 1'b0 : w_alu_tk;
                            r_out_target <= is_mul(w_op) ? '0 : w_alu_tgt;
                        end
                    end
                    MUL: begin
                        if (r_cnt == 3'(MUL_LAT - 2)) begin
                            r_state      <= IDLE;
                            r_cnt        <= '0;
                            r_out_valid  <= 1'b1;
                            r_out_tag    <= r_tag;
                            r_out_val    <= r_mul_pipe[MP-1];
                            r_out_taken  <= 1'b0;
                            r_out_target <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    DIV: begin
                        if (w_div_done) begin
                            r_state      <= IDLE;
                            r_out_valid  <= 1'b1;
                            r_out_tag    <= r_tag;
                            r_out_val    <= r_is_rem ? w_div_rem : w_div_quot;
                            r_out_taken  <= 1'b0;
                            r_out_target <= '0;
                        end else if (!w_div_busy) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_tag    = r_out_tag;
    assign out_val    = r_out_val;
    assign out_taken  = r_out_taken;
    assign out_target = r_out_target;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU/branch/JALR vectors, mul/div latency, backpressure, flush, stall, reset.
module tb_exec_unit;
    import exec_unit_pkg::*;

    localparam int XLEN    = 32;
    localparam int ID_W    = 4;
    localparam int MUL_LAT = 3;

    logic            clk;
    logic            rst_in;
    logic            rdy_in;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [XLEN-1:0] in_pc;
    logic [ID_W-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [ID_W-1:0] out_tag;
    logic [XLEN-1:0] out_val;
    logic            out_taken;
    logic [XLEN-1:0] out_target;

    int n_vec = 0;
    int n_err = 0;

    exec_unit #(.XLEN(XLEN), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_pc      (in_pc),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .out_val    (out_val),
        .out_taken  (out_taken),
        .out_target (out_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [3:0] t);
        chk("in_ready_pre", in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_pc    = pc;
        in_tag   = t;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic alu(input string nm, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [3:0] t,
                       input logic [31:0] ev, input logic etk, input logic [31:0] etg);
        issue(op, a, b, pc, t);
        chk({nm, ".valid"},  out_valid, 1);
        chk({nm, ".val"},    out_val, ev);
        chk({nm, ".taken"},  out_taken, etk);
        chk({nm, ".target"}, out_target, etg);
        chk({nm, ".tag"},    out_tag, t);
        tick();
        chk({nm, ".drain"},  out_valid, 0);
    endtask

    task automatic longop(input string nm, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t,
                          input logic [31:0] ev, input int elat);
        int n;
        issue(op, a, b, 32'h0, t);
        n = 1;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({nm, ".lat"}, n, elat);
        chk({nm, ".val"}, out_val, ev);
        chk({nm, ".tag"}, out_tag, t);
        tick();
        chk({nm, ".drain"}, out_valid, 0);
    endtask

    initial begin
        int n;
        int n_hi;
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_pc     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst.valid",  out_valid, 0);
        chk("rst.val",    out_val, 0);
        chk("rst.tag",    out_tag, 0);
        chk("rst.taken",  out_taken, 0);
        chk("rst.target", out_target, 0);
        rst_in = 1'b0;
        tick();
        chk("rst.in_ready", in_ready, 1);

        alu("sub",   OP_SUB,  32'd5,        32'd7,  32'h0,   4'd3,  32'hFFFFFFFE, 1'b0, 32'h0);
        alu("slt",   OP_SLT,  32'hFFFFFFFF, 32'd1,  32'h0,   4'd1,  32'd1,        1'b0, 32'h0);
        alu("sltu",  OP_SLTU, 32'hFFFFFFFF, 32'd1,  32'h0,   4'd2,  32'd0,        1'b0, 32'h0);
        alu("sra",   OP_SRA,  32'h80000000, 32'h21, 32'h0,   4'd4,  32'hC0000000, 1'b0, 32'h0);
        alu("srl",   OP_SRL,  32'h80000000, 32'h21, 32'h0,   4'd5,  32'h40000000, 1'b0, 32'h0);
        alu("sll",   OP_SLL,  32'd1,        32'd3,  32'h0,   4'd6,  32'd8,        1'b0, 32'h0);
        alu("xor",   OP_XOR,  32'hF0,       32'hFF, 32'h0,   4'd7,  32'h0F,       1'b0, 32'h0);
        alu("blt",   OP_BLT,  32'hFFFFFFFF, 32'd1,  32'h0,   4'd8,  32'd0,        1'b1, 32'h0);
        alu("bge",   OP_BGE,  32'hFFFFFFFF, 32'd1,  32'h0,   4'd9,  32'd0,        1'b0, 32'h0);
        alu("bltu",  OP_BLTU, 32'hFFFFFFFF, 32'd1,  32'h0,   4'd10, 32'd0,        1'b0, 32'h0);
        alu("bgeu",  OP_BGEU, 32'hFFFFFFFF, 32'd1,  32'h0,   4'd11, 32'd0,        1'b1, 32'h0);
        alu("beq",   OP_BEQ,  32'd5,        32'd5,  32'h0,   4'd12, 32'd0,        1'b1, 32'h0);
        alu("bne",   OP_BNE,  32'd5,        32'd5,  32'h0,   4'd13, 32'd0,        1'b0, 32'h0);
        alu("jalr",  OP_JALR, 32'h1001,     32'd4,  32'h200, 4'd14, 32'h204,      1'b1, 32'h1004);
        alu("undef", 5'd31,   32'd2,        32'd3,  32'h0,   4'd15, 32'd5,        1'b0, 32'h0);

        longop("div_ovf",  OP_DIV,    32'h80000000, 32'hFFFFFFFF, 4'd1, 32'h80000000, 33);
        longop("rem_ovf",  OP_REM,    32'h80000000, 32'hFFFFFFFF, 4'd2, 32'h0,        33);
        longop("divu_dz",  OP_DIVU,   32'd7,        32'd0,        4'd3, 32'hFFFFFFFF, 33);
        longop("rem_dz",   OP_REM,    32'd7,        32'd0,        4'd4, 32'd7,        33);
        longop("div_neg",  OP_DIV,    32'hFFFFFFF9, 32'd2,        4'd5, 32'hFFFFFFFD, 33);
        longop("rem_neg",  OP_REM,    32'hFFFFFFF9, 32'd2,        4'd6, 32'hFFFFFFFF, 33);
        longop("remu",     OP_REMU,   32'd100,      32'd7,        4'd7, 32'd2,        33);
        longop("mul",      OP_MUL,    32'd6,        32'd7,        4'd8, 32'd42,       3);
        longop("mul_lo",   OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9, 32'd1,        3);
        longop("mulh",     OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 4'd10, 32'd0,       3);
        longop("mulhsu",   OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd11, 32'hFFFFFFFF, 3);
        longop("mulhu",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd12, 32'hFFFFFFFE, 3);

        // Result held under backpressure
        out_ready = 1'b0;
        issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'd9);
        n = 1;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bp.lat", n, 3);
        for (int i = 0; i < 4; i++) begin
            chk("bp.valid",    out_valid, 1);
            chk("bp.val",      out_val, 32'hFFFFFFFE);
            chk("bp.tag",      out_tag, 4'd9);
            chk("bp.in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready_hs", in_ready, 1);
        chk("bp.val_hs",      out_val, 32'hFFFFFFFE);
        tick();
        chk("bp.freed", out_valid, 0);

        // Flush at DIV cycle 10
        issue(OP_DIVU, 32'd100, 32'd7, 32'h0, 4'd5);
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.valid",    out_valid, 0);
        chk("flush.in_ready", in_ready, 1);
        n_hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) n_hi++;
        end
        chk("flush.no_out", n_hi, 0);

        // rdy_in low 5 cycles mid-MUL; a flush during the stall is ignored
        issue(OP_MUL, 32'd3, 32'd5, 32'h0, 4'd6);
        n = 1;
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            chk("stall.in_ready", in_ready, 0);
            tick();
            n++;
        end
        flush  = 1'b0;
        rdy_in = 1'b1;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("stall.lat", n, 8);
        chk("stall.val", out_val, 32'd15);
        chk("stall.tag", out_tag, 4'd6);
        tick();
        chk("stall.drain", out_valid, 0);

        // Reset mid-DIV
        issue(OP_DIV, 32'd1000, 32'd3, 32'h0, 4'd7);
        for (int i = 0; i < 5; i++) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("rstdiv.valid",    out_valid, 0);
        chk("rstdiv.tag",      out_tag, 0);
        chk("rstdiv.in_ready", in_ready, 1);
        n_hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) n_hi++;
        end
        chk("rstdiv.no_out", n_hi, 0);

        // Flush beats a simultaneous issue
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_a     = 32'd1;
        in_b     = 32'd1;
        in_tag   = 4'd3;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_acc.valid", out_valid, 0);

        // Flush kills a result waiting on backpressure
        out_ready = 1'b0;
        issue(OP_ADD, 32'd1, 32'd2, 32'h0, 4'd2);
        chk("flush_bp.valid", out_valid, 1);
        chk("flush_bp.val",   out_val, 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_bp.killed", out_valid, 0);
        out_ready = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
